// File: rtl/cnt_down_hms.sv
`default_nettype none
// ============================================================================
// Module   : cnt_down_hms
// Brief    : Loadable HH:MM:SS countdown timer with load/start/stop/clear
//            control, one-cycle done pulse and latched alarm.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_down_hms #(
    parameter int MAX_H = 23,
    parameter int MAX_M = 59,
    parameter int MAX_S = 59
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       tick,
    input  logic       load,
    input  logic [6:0] load_h,
    input  logic [6:0] load_m,
    input  logic [6:0] load_s,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [6:0] hours,
    output logic [6:0] minutes,
    output logic [6:0] seconds,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       alarm
);

    localparam logic [6:0] C_MAX_H = 7'(MAX_H);
    localparam logic [6:0] C_MAX_M = 7'(MAX_M);
    localparam logic [6:0] C_MAX_S = 7'(MAX_S);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] h_q, h_d;
    logic [6:0] m_q, m_d;
    logic [6:0] s_q, s_d;
    logic       done_q, done_d;
    logic       alarm_q, alarm_d;

    logic       w_nonzero;
    logic       w_last_sec;

    assign w_nonzero  = (h_q != 7'd0) || (m_q != 7'd0) || (s_q != 7'd0);
    assign w_last_sec = (h_q == 7'd0) && (m_q == 7'd0) && (s_q == 7'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            h_q     <= 7'd0;
            m_q     <= 7'd0;
            s_q     <= 7'd0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            done_q  <= done_d;
            alarm_q <= alarm_d;
        end
    end

    // Strict priority: an active higher event consumes the cycle even when it
    // has no effect in the current state, so lower events are dropped.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        done_d  = 1'b0;
        alarm_d = alarm_q;

        if (clear) begin
            state_d = ST_IDLE;
            h_d     = 7'd0;
            m_d     = 7'd0;
            s_d     = 7'd0;
            alarm_d = 1'b0;
        end else if (load) begin
            if (state_q != ST_RUN) begin
                h_d     = (load_h > C_MAX_H) ? C_MAX_H : load_h;
                m_d     = (load_m > C_MAX_M) ? C_MAX_M : load_m;
                s_d     = (load_s > C_MAX_S) ? C_MAX_S : load_s;
                state_d = ST_IDLE;
                alarm_d = 1'b0;
            end
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start) begin
            if ((state_q == ST_IDLE || state_q == ST_PAUSE) && w_nonzero) begin
                state_d = ST_RUN;
            end
        end else if (tick) begin
            if (state_q == ST_RUN && w_nonzero) begin
                if (s_q != 7'd0) begin
                    s_d = s_q - 7'd1;
                end else if (m_q != 7'd0) begin
                    s_d = C_MAX_S;
                    m_d = m_q - 7'd1;
                end else begin
                    s_d = C_MAX_S;
                    m_d = C_MAX_M;
                    h_d = h_q - 7'd1;
                end
                if (w_last_sec) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    alarm_d = 1'b1;
                end
            end
        end
    end

    assign hours   = h_q;
    assign minutes = m_q;
    assign seconds = s_q;
    assign state   = state_q;
    assign running = (state_q == ST_RUN);
    assign done    = done_q;
    assign alarm   = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_cnt_down_hms.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_down_hms
// Brief    : Directed self-checking bench for the HH:MM:SS countdown timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_down_hms;

    logic       rst;
    logic       clk;
    logic       tick;
    logic       load;
    logic [6:0] load_h;
    logic [6:0] load_m;
    logic [6:0] load_s;
    logic       start;
    logic       stop;
    logic       clear;
    logic [6:0] hours;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic [1:0] state;
    logic       running;
    logic       done;
    logic       alarm;

    int n_cmp  = 0;
    int n_fail = 0;

    cnt_down_hms #(
        .MAX_H(23),
        .MAX_M(59),
        .MAX_S(59)
    ) u_dut (
        .rst    (rst),
        .clk    (clk),
        .tick   (tick),
        .load   (load),
        .load_h (load_h),
        .load_m (load_m),
        .load_s (load_s),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
        .hours  (hours),
        .minutes(minutes),
        .seconds(seconds),
        .state  (state),
        .running(running),
        .done   (done),
        .alarm  (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_hms(input string tag, input int h, input int m, input int s);
        chk(tag, {11'd0, hours, minutes, seconds}, {11'd0, 7'(h), 7'(m), 7'(s)});
    endtask

    // Inputs change at negedge, take effect on the next posedge; results are
    // observable from 1 time unit after that edge.
    task automatic step(input logic ld, input logic st, input logic sp,
                        input logic cl, input logic tk,
                        input int h, input int m, input int s);
        @(negedge clk);
        load   = ld;
        start  = st;
        stop   = sp;
        clear  = cl;
        tick   = tk;
        load_h = 7'(h);
        load_m = 7'(m);
        load_s = 7'(s);
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, h, m, s);
    endtask
    task automatic do_start();  step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0); endtask
    task automatic do_clear();  step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0); endtask
    task automatic do_tick();   step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0); endtask
    task automatic do_idle();   step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0); endtask

    initial begin
        rst    = 1'b0;
        tick   = 1'b0;
        load   = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        clear  = 1'b0;
        load_h = 7'd0;
        load_m = 7'd0;
        load_s = 7'd0;

        #2;
        chk_hms("reset_count", 0, 0, 0);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_alarm", 32'(alarm), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset in the middle of a run
        do_load(1, 0, 0);
        do_start();
        for (int i = 0; i < 3; i++) do_tick();
        chk_hms("run_3_ticks", 0, 59, 57);
        chk("run_state", 32'(state), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_hms("async_rst_count", 0, 0, 0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_running", 32'(running), 32'd0);
        chk("async_rst_alarm", 32'(alarm), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Seconds borrow into minutes
        do_load(0, 1, 5);
        do_start();
        for (int i = 0; i < 5; i++) do_tick();
        chk_hms("sec_down_to_0", 0, 1, 0);
        do_tick();
        chk_hms("sec_borrow", 0, 0, 59);

        // Borrow across minutes and hours
        do_clear();
        do_load(1, 0, 0);
        do_start();
        do_tick();
        chk_hms("hour_borrow", 0, 59, 59);
        chk("hour_borrow_running", 32'(running), 32'd1);

        // Expiry
        do_clear();
        do_load(0, 0, 2);
        do_start();
        do_tick();
        chk_hms("exp_one_left", 0, 0, 1);
        chk("exp_no_early_done", 32'(done), 32'd0);
        do_tick();
        chk_hms("exp_zero", 0, 0, 0);
        chk("exp_done_pulse", 32'(done), 32'd1);
        chk("exp_alarm", 32'(alarm), 32'd1);
        chk("exp_state", 32'(state), 32'd3);
        chk("exp_running", 32'(running), 32'd0);
        do_idle();
        chk("exp_done_one_cycle", 32'(done), 32'd0);
        chk("exp_alarm_held", 32'(alarm), 32'd1);
        for (int i = 0; i < 5; i++) do_tick();
        chk_hms("exp_no_wrap", 0, 0, 0);
        chk("exp_state_held", 32'(state), 32'd3);
        chk("exp_done_stays_low", 32'(done), 32'd0);
        do_start();
        chk("exp_start_ignored", 32'(state), 32'd3);
        do_clear();
        chk("exp_clear_alarm", 32'(alarm), 32'd0);
        chk("exp_clear_state", 32'(state), 32'd0);

        // Stop outranks a coincident tick
        do_load(0, 0, 10);
        do_start();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        chk_hms("pause_tick_dropped", 0, 0, 10);
        chk("pause_state", 32'(state), 32'd2);
        do_tick();
        chk_hms("pause_tick_ignored", 0, 0, 10);
        do_start();
        chk("resume_state", 32'(state), 32'd1);
        do_tick();
        chk_hms("resume_tick", 0, 0, 9);

        // Clamping and guards
        do_clear();
        do_load(30, 75, 99);
        chk_hms("load_clamp", 23, 59, 59);
        chk("load_clamp_state", 32'(state), 32'd0);
        do_clear();
        do_start();
        chk("start_zero_ignored", 32'(state), 32'd0);
        do_load(0, 0, 20);
        do_start();
        do_load(0, 0, 5);
        chk_hms("load_in_run_ignored", 0, 0, 20);
        chk("load_in_run_state", 32'(state), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 5);
        chk_hms("clear_over_load", 0, 0, 0);
        chk("clear_over_load_state", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
